execute_cycle: RTL and testbench
================================

// Module: execute_cycle
// PURPOSE
//   Execute stage of the 5-stage pipeline. It consumes the E-stage register outputs of the decode stage
//   and applies operand forwarding. It runs the ALU and resolves beq branches, returning PCSrcE/PCTargetE
//   to fetch. Its E->M pipeline register feeds the memory stage.
// PARAMETERS
//   (none; widths fixed at 32-bit data, 5-bit register index, 3-bit ALU control)
// PORTS
//   clk          in   1   clock; all state updates on rising edge
//   rst          in   1   synchronous, active-high reset
//   RegWriteE    in   1   E-stage register-write enable
//   ALUSrcE      in   1   0: SrcB = forwarded RD2; 1: SrcB = Imm_Ext_E
//   MemWriteE    in   1   E-stage store enable
//   ResultSrcE   in   1   0: writeback ALU result; 1: writeback load data
//   BranchE      in   1   instruction is beq
//   ALUControlE  in   3   ALU operation select
//   RD1_E        in   32  rs1 register-file value
//   RD2_E        in   32  rs2 register-file value
//   Imm_Ext_E    in   32  sign-extended immediate
//   RD_E         in   5   destination register index
//   PCE          in   32  instruction PC
//   PCPlus4E     in   32  PC+4
//   ResultW      in   32  writeback-stage result (forwarding source)
//   ForwardAE    in   2   SrcA select: 00 RD1_E, 01 ResultW, 10 ALU_ResultM, 11 RD1_E
//   ForwardBE    in   2   same encoding, applied to RD2_E
//   KillE        in   1   squash the instruction currently in E
//   PCSrcE       out  1   branch taken (combinational)
//   PCTargetE    out  32  PCE + Imm_Ext_E (combinational)
//   RegWriteM    out  1   registered RegWriteE
//   MemWriteM    out  1   registered MemWriteE
//   ResultSrcM   out  1   registered ResultSrcE
//   RD_M         out  5   registered RD_E
//   PCPlus4M     out  32  registered PCPlus4E
//   WriteDataM   out  32  registered forwarded rs2 value (store data), before the ALUSrc mux
//   ALU_ResultM  out  32  registered ALU result
// BEHAVIOUR
//   - Reset: rising edge with rst=1 clears every registered output to 0. While rst=1, PCSrcE=0.
//   - Latency: one cycle. E inputs at edge N appear on the M outputs after edge N.
//   - ALU, 32-bit, mod 2^32, overflow ignored:
//       000 add; 001 sub (SrcA-SrcB); 010 and; 011 or.
//       101 slt: signed, result 1/0 zero-extended.
//       Other codes: result 0.
//   - ZeroE = (ALU result == 0). PCSrcE = BranchE & ZeroE & ~KillE & ~rst.
//   - PCTargetE = PCE + Imm_Ext_E, mod 2^32, never gated.
//   - Forwarding is combinational.
//       Code 10 selects the current ALU_ResultM register, giving a back-to-back ALU dependency.
//       Code 01 selects ResultW.
//       Code 11 is treated as 00.
//   - KillE=1 at an edge loads RegWriteM=0, MemWriteM=0 and ResultSrcM=0, inserting a bubble.
//       The data fields still load normally.
//   - Priority at an edge: rst > KillE > normal load.
//   - Reset mid-stream: the instruction in E is lost. No partial state survives.
// CONFIGURATION
//   EXECUTE_FORWARDING_EN
//     Defined: forwarding muxes active as described above.
//     Undefined: ForwardAE/ForwardBE are ignored, and SrcA=RD1_E, rs2 value=RD2_E always.
//       The ports stay present. Hazards must then be removed by stalls upstream.
// TESTING
//   - Reset: hold rst=1 for 2 cycles with nonzero inputs, then check:
//       all M outputs 0; PCSrcE=0 even with BranchE=1, RD1_E=RD2_E.
//   - ALU ops, ALUSrc=0: RD1_E=7, RD2_E=9.
//       add -> ALU_ResultM=16; sub -> 0xFFFFFFFE; and -> 1; or -> 15; slt -> 1.
//   - Signed slt: RD1_E=0x80000000, RD2_E=1 -> ALU_ResultM=1.
//   - Immediate: ALUSrcE=1, Imm_Ext_E=-4, RD1_E=4, add -> ALU_ResultM=0.
//       WriteDataM=RD2_E.
//   - Branch: BranchE=1, sub, RD1_E=RD2_E=5, PCE=0x100, Imm_Ext_E=0x20:
//       PCSrcE=1 and PCTargetE=0x120 in the same cycle.
//       Repeat with KillE=1 -> PCSrcE=0, RegWriteM=0 next cycle.
//   - Forwarding (macro defined): cycle 1 add 3+4.
//       Cycle 2 ForwardAE=10, RD1_E=0, RD2_E=1, add -> ALU_ResultM=8.
//       ForwardBE=01 with ResultW=0x55, ALUSrcE=0, or, SrcA=0 -> WriteDataM=0x55.
//       Macro undefined: same stimulus gives ALU_ResultM=1.

Source files
------------

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, beq resolution and the E->M register.
// Optional macro EXECUTE_FORWARDING_EN enables the ForwardAE/ForwardBE muxes.
module execute_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        ALUSrcE,
    input  logic        MemWriteE,
    input  logic        ResultSrcE,
    input  logic        BranchE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [4:0]  RD_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [31:0] ResultW,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic        KillE,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] PCPlus4M,
    output logic [31:0] WriteDataM,
    output logic [31:0] ALU_ResultM
);

    logic        regwrite_q, regwrite_d;
    logic        memwrite_q, memwrite_d;
    logic        resultsrc_q, resultsrc_d;
    logic [4:0]  rd_q;
    logic [31:0] pcplus4_q;
    logic [31:0] wdata_q;
    logic [31:0] alu_q;

    logic [31:0] src_a;
    logic [31:0] rs2_val;
    logic [31:0] src_b;
    logic [31:0] alu_res;
    logic        zero;

`ifdef EXECUTE_FORWARDING_EN
    // Code 10 reads our own M register for back-to-back ALU dependencies.
    always_comb begin
        src_a = RD1_E;
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = alu_q;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        rs2_val = RD2_E;
        case (ForwardBE)
            2'b01:   rs2_val = ResultW;
            2'b10:   rs2_val = alu_q;
            default: rs2_val = RD2_E;
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{ForwardAE, ForwardBE, ResultW};
    assign src_a      = RD1_E;
    assign rs2_val    = RD2_E;
`endif

    assign src_b = ALUSrcE ? Imm_Ext_E : rs2_val;

    always_comb begin
        alu_res = 32'd0;
        case (ALUControlE)
            3'b000: alu_res = src_a + src_b;
            3'b001: alu_res = src_a - src_b;
            3'b010: alu_res = src_a & src_b;
            3'b011: alu_res = src_a | src_b;
            3'b101: alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
            default: alu_res = 32'd0;
        endcase
    end

    assign zero      = (alu_res == 32'd0);
    assign PCSrcE    = BranchE & zero & ~KillE & ~rst;
    assign PCTargetE = PCE + Imm_Ext_E;

    // A killed instruction keeps its data but loses every side effect.
    assign regwrite_d  = RegWriteE & ~KillE;
    assign memwrite_d  = MemWriteE & ~KillE;
    assign resultsrc_d = ResultSrcE & ~KillE;

    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_q  <= 1'b0;
            memwrite_q  <= 1'b0;
            resultsrc_q <= 1'b0;
            rd_q        <= 5'd0;
            pcplus4_q   <= 32'd0;
            wdata_q     <= 32'd0;
            alu_q       <= 32'd0;
        end else begin
            regwrite_q  <= regwrite_d;
            memwrite_q  <= memwrite_d;
            resultsrc_q <= resultsrc_d;
            rd_q        <= RD_E;
            pcplus4_q   <= PCPlus4E;
            wdata_q     <= rs2_val;
            alu_q       <= alu_res;
        end
    end

    assign RegWriteM   = regwrite_q;
    assign MemWriteM   = memwrite_q;
    assign ResultSrcM  = resultsrc_q;
    assign RD_M        = rd_q;
    assign PCPlus4M    = pcplus4_q;
    assign WriteDataM  = wdata_q;
    assign ALU_ResultM = alu_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle with a scoreboard of expected M-stage values.
// Expectations follow EXECUTE_FORWARDING_EN the same way as the design.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        KillE;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

    typedef struct {
        logic        regw;
        logic        memw;
        logic        rsrc;
        logic [4:0]  rd;
        logic [31:0] pcp4;
        logic [31:0] wd;
        logic [31:0] alu;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE),
        .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
        .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .ResultW(ResultW), .ForwardAE(ForwardAE),
        .ForwardBE(ForwardBE), .KillE(KillE),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .RD_M(RD_M),
        .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
        .ALU_ResultM(ALU_ResultM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic regw, input logic memw,
                                input logic rsrc, input logic [4:0] rd,
                                input logic [31:0] pcp4,
                                input logic [31:0] wd,
                                input logic [31:0] alu);
        exp_t e;
        e.regw = regw; e.memw = memw; e.rsrc = rsrc;
        e.rd = rd; e.pcp4 = pcp4; e.wd = wd; e.alu = alu;
        return e;
    endfunction

    task automatic tick_and_check(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_RegWriteM"},  {31'd0, RegWriteM},  {31'd0, e.regw});
            chk({tag, "_MemWriteM"},  {31'd0, MemWriteM},  {31'd0, e.memw});
            chk({tag, "_ResultSrcM"}, {31'd0, ResultSrcM}, {31'd0, e.rsrc});
            chk({tag, "_RD_M"},       {27'd0, RD_M},       {27'd0, e.rd});
            chk({tag, "_PCPlus4M"},   PCPlus4M,            e.pcp4);
            chk({tag, "_WriteDataM"}, WriteDataM,          e.wd);
            chk({tag, "_ALU_ResultM"}, ALU_ResultM,        e.alu);
        end
    endtask

    initial begin
        logic [2:0]  ops  [5];
        logic [31:0] exps [5];
        logic [31:0] fwd_alu, fwd_wd;
        ops  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
        exps = '{32'd16, 32'hFFFF_FFFE, 32'd1, 32'd15, 32'd1};

        // Reset with busy inputs; beq operands equal so only rst gates PCSrcE
        rst = 1'b1;
        RegWriteE = 1'b1; ALUSrcE = 1'b0; MemWriteE = 1'b1;
        ResultSrcE = 1'b1; BranchE = 1'b1; ALUControlE = 3'b001;
        RD1_E = 32'd5; RD2_E = 32'd5; Imm_Ext_E = 32'h20;
        RD_E = 5'd7; PCE = 32'h100; PCPlus4E = 32'h104;
        ResultW = 32'hAA; ForwardAE = 2'b00; ForwardBE = 2'b00;
        KillE = 1'b0;
        @(posedge clk);
        sb.push_back(mk(0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0));
        tick_and_check("reset");
        chk("reset_PCSrcE", {31'd0, PCSrcE}, 32'd0);

        rst = 1'b0;
        BranchE = 1'b0; MemWriteE = 1'b0; ResultSrcE = 1'b0;

        // Register-register ALU ops
        for (int i = 0; i < 5; i++) begin
            ALUControlE = ops[i];
            RD1_E = 32'd7; RD2_E = 32'd9;
            RD_E = 5'(i + 1);
            PCPlus4E = 32'h1000 + 32'(4 * i);
            sb.push_back(mk(1, 0, 0, 5'(i + 1), 32'h1000 + 32'(4 * i),
                            32'd9, exps[i]));
            tick_and_check($sformatf("alu%0d", i));
        end

        ALUControlE = 3'b111;
        RD_E = 5'd9; PCPlus4E = 32'h2000;
        sb.push_back(mk(1, 0, 0, 5'd9, 32'h2000, 32'd9, 32'd0));
        tick_and_check("alu_undef");

        ALUControlE = 3'b101;
        RD1_E = 32'h8000_0000; RD2_E = 32'd1;
        RD_E = 5'd10; PCPlus4E = 32'h2004;
        sb.push_back(mk(1, 0, 0, 5'd10, 32'h2004, 32'd1, 32'd1));
        tick_and_check("slt_signed");

        ALUControlE = 3'b000; ALUSrcE = 1'b1;
        Imm_Ext_E = 32'hFFFF_FFFC; RD1_E = 32'd4; RD2_E = 32'h1234;
        RD_E = 5'd11; PCPlus4E = 32'h2008;
        sb.push_back(mk(1, 0, 0, 5'd11, 32'h2008, 32'h1234, 32'd0));
        tick_and_check("imm_add");

        // beq taken, outputs valid in the same cycle
        ALUSrcE = 1'b0; BranchE = 1'b1; ALUControlE = 3'b001;
        RD1_E = 32'd5; RD2_E = 32'd5; PCE = 32'h100; Imm_Ext_E = 32'h20;
        MemWriteE = 1'b1; ResultSrcE = 1'b1;
        RD_E = 5'd12; PCPlus4E = 32'h104;
        #1;
        chk("br_PCSrcE", {31'd0, PCSrcE}, 32'd1);
        chk("br_PCTargetE", PCTargetE, 32'h120);
        sb.push_back(mk(1, 1, 1, 5'd12, 32'h104, 32'd5, 32'd0));
        tick_and_check("br");

        KillE = 1'b1;
        #1;
        chk("kill_PCSrcE", {31'd0, PCSrcE}, 32'd0);
        chk("kill_PCTargetE", PCTargetE, 32'h120);
        sb.push_back(mk(0, 0, 0, 5'd12, 32'h104, 32'd5, 32'd0));
        tick_and_check("kill");

        KillE = 1'b0; RD2_E = 32'd6;
        MemWriteE = 1'b0; ResultSrcE = 1'b0;
        #1;
        chk("br_nt_PCSrcE", {31'd0, PCSrcE}, 32'd0);
        sb.push_back(mk(1, 0, 0, 5'd12, 32'h104, 32'd6, 32'hFFFF_FFFF));
        tick_and_check("br_nt");

        // Forwarding chain
        BranchE = 1'b0; ALUControlE = 3'b000;
        RD1_E = 32'd3; RD2_E = 32'd4; RD_E = 5'd13; PCPlus4E = 32'h3000;
        sb.push_back(mk(1, 0, 0, 5'd13, 32'h3000, 32'd4, 32'd7));
        tick_and_check("fwd_c1");

`ifdef EXECUTE_FORWARDING_EN
        fwd_alu = 32'd8;
`else
        fwd_alu = 32'd1;
`endif
        ForwardAE = 2'b10; RD1_E = 32'd0; RD2_E = 32'd1;
        RD_E = 5'd14; PCPlus4E = 32'h3004;
        sb.push_back(mk(1, 0, 0, 5'd14, 32'h3004, 32'd1, fwd_alu));
        tick_and_check("fwd_c2");

`ifdef EXECUTE_FORWARDING_EN
        fwd_alu = 32'h55; fwd_wd = 32'h55;
`else
        fwd_alu = 32'd2; fwd_wd = 32'd2;
`endif
        ForwardAE = 2'b00; ForwardBE = 2'b01; ResultW = 32'h55;
        ALUControlE = 3'b011; RD1_E = 32'd0; RD2_E = 32'd2;
        RD_E = 5'd15; PCPlus4E = 32'h3008;
        sb.push_back(mk(1, 0, 0, 5'd15, 32'h3008, fwd_wd, fwd_alu));
        tick_and_check("fwd_c3");

        // Code 11 behaves as 00 in either build
        ForwardAE = 2'b11; ForwardBE = 2'b11; ALUControlE = 3'b000;
        RD1_E = 32'h10; RD2_E = 32'd1; ResultW = 32'h700;
        RD_E = 5'd16; PCPlus4E = 32'h300C;
        sb.push_back(mk(1, 0, 0, 5'd16, 32'h300C, 32'd1, 32'h11));
        tick_and_check("fwd_11");

        // Reset mid-stream drops the instruction in E
        ForwardAE = 2'b00; ForwardBE = 2'b00;
        MemWriteE = 1'b1; RD1_E = 32'h42; rst = 1'b1;
        sb.push_back(mk(0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0));
        tick_and_check("mid_rst");
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
